// File: rtl/str_pair_assembler_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : str_pair_pkg
//  Brief   : Shared types and constants for the string-pair assembler and
//            the downstream string-pair checking stage.
//  Rev     : 1.0  initial release
// ============================================================================
package str_pair_pkg;

    // Assembled pair handed to the consumer as a whole
    typedef struct {
        string fst;
        string snd;
    } str_pair_t;

    // Field separator ',' and end-of-line '\n'
    localparam byte SEP_CHAR = 8'h2C;
    localparam byte EOL_CHAR = 8'h0A;

    // Assembler states
    typedef enum logic [1:0] {
        S_FST = 2'd0,
        S_SND = 2'd1,
        S_OUT = 2'd2
    } state_t;

endpackage : str_pair_pkg
`default_nettype wire

// File: rtl/str_pair_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module  : str_pair_assembler_if
//  Brief   : Character-in / pair-out handshake bundle. The slave modport is
//            the assembler; the master modport is its environment.
//  Rev     : 1.0  initial release
// ============================================================================
interface str_pair_assembler_if;
    import str_pair_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       out_valid;
    logic       out_ready;
    str_pair_t  out_pair;
    logic       out_err;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_char,
        output out_valid,
        input  out_ready,
        output out_pair,
        output out_err
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_char,
        input  out_valid,
        output out_ready,
        input  out_pair,
        input  out_err
    );

endinterface : str_pair_assembler_if
`default_nettype wire

// File: rtl/str_pair_assembler.sv
`default_nettype none
// ============================================================================
//  Module  : str_pair_assembler
//  Brief   : Assembles a str_pair_t from a byte stream. ',' closes fst,
//            '\n' closes snd, NUL is discarded, overlong fields are
//            truncated with a sticky error flag. The pair is then offered
//            on a valid/ready handshake.
//  Config  : STR_PAIR_ASM_STATS_EN adds the pair_cnt port and counter.
//  Rev     : 1.0  initial release
// ============================================================================
module str_pair_assembler
    import str_pair_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    str_pair_assembler_if.slave    bus
`ifdef STR_PAIR_ASM_STATS_EN
    ,
    output logic [CNT_W-1:0]       pair_cnt
`endif
);

    // Append one character unless the field is already full
    function automatic string append_char(input string field, input logic [7:0] ch,
                                          output logic dropped);
        if (field.len() < MAX_LEN) begin
            dropped = 1'b0;
            return {field, string'(ch)};
        end
        dropped = 1'b1;
        return field;
    endfunction

    state_t     r_state;
    state_t     w_state_next;
    string      r_fst;
    string      r_snd;
    logic       r_err;
    string      w_fst_next;
    string      w_snd_next;
    logic       w_err_next;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_app_fst;
    logic       w_app_snd;
    logic       w_handshake;
    logic       w_drop;

    // Ready is a pure function of state so it never loops back combinationally
    assign w_in_ready = (r_state != S_OUT);
    assign w_accept   = bus.in_valid && w_in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and append/handshake strobes
    always_comb begin
        w_state_next = r_state;
        w_app_fst    = 1'b0;
        w_app_snd    = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            S_FST: begin
                if (w_accept && (bus.in_char != 8'h00)) begin
                    if (bus.in_char == SEP_CHAR) begin
                        w_state_next = S_SND;
                    end else if (bus.in_char == EOL_CHAR) begin
                        w_state_next = S_OUT;
                    end else begin
                        w_app_fst = 1'b1;
                    end
                end
            end
            S_SND: begin
                if (w_accept && (bus.in_char != 8'h00)) begin
                    if (bus.in_char == EOL_CHAR) begin
                        w_state_next = S_OUT;
                    end else begin
                        w_app_snd = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = S_FST;
                end
            end
            default: begin
                w_state_next = S_FST;
            end
        endcase
    end

    // Field datapath: append into the open field, clear after delivery
    always_comb begin
        w_fst_next = r_fst;
        w_snd_next = r_snd;
        w_err_next = r_err;
        w_drop     = 1'b0;
        if (w_handshake) begin
            w_fst_next = "";
            w_snd_next = "";
            w_err_next = 1'b0;
        end else if (w_app_fst) begin
            w_fst_next = append_char(r_fst, bus.in_char, w_drop);
            w_err_next = r_err | w_drop;
        end else if (w_app_snd) begin
            w_snd_next = append_char(r_snd, bus.in_char, w_drop);
            w_err_next = r_err | w_drop;
        end
    end

    // Field registers; frozen while the pair waits in S_OUT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fst <= "";
            r_snd <= "";
            r_err <= 1'b0;
        end else begin
            r_fst <= w_fst_next;
            r_snd <= w_snd_next;
            r_err <= w_err_next;
        end
    end

    // Outputs come straight from state and the frozen field registers
    always_comb begin
        bus.in_ready     = w_in_ready;
        bus.out_valid    = (r_state == S_OUT);
        bus.out_err      = r_err;
        bus.out_pair.fst = r_fst;
        bus.out_pair.snd = r_snd;
    end

`ifdef STR_PAIR_ASM_STATS_EN
    logic [CNT_W-1:0] r_pair_cnt;

    // Count completed handshakes, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pair_cnt <= '0;
        end else if (w_handshake) begin
            r_pair_cnt <= r_pair_cnt + CNT_W'(1);
        end
    end

    assign pair_cnt = r_pair_cnt;
`else
    if (CNT_W > 0) begin : g_no_stats
    end
`endif

endmodule : str_pair_assembler
`default_nettype wire

// File: tb/tb_str_pair_assembler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_str_pair_assembler
//  Brief   : Directed bench for str_pair_assembler. Three instances cover the
//            default build, MAX_LEN = 4 and CNT_W = 2; sel picks which one
//            is being driven and observed.
//  Config  : honours STR_PAIR_ASM_STATS_EN for the pair_cnt checks.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_str_pair_assembler;
    import str_pair_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_char = 8'h00;
    logic       tb_oready = 1'b1;
    int         sel = 0;

    int n_cmp = 0;
    int n_err = 0;

    string q_fst[$];
    string q_snd[$];
    logic  q_err[$];

    always #5 clk = ~clk;

    str_pair_assembler_if bus0 ();
    str_pair_assembler_if bus1 ();
    str_pair_assembler_if bus2 ();

    assign bus0.in_valid  = tb_valid && (sel == 0);
    assign bus1.in_valid  = tb_valid && (sel == 1);
    assign bus2.in_valid  = tb_valid && (sel == 2);
    assign bus0.in_char   = tb_char;
    assign bus1.in_char   = tb_char;
    assign bus2.in_char   = tb_char;
    assign bus0.out_ready = tb_oready && (sel == 0);
    assign bus1.out_ready = tb_oready && (sel == 1);
    assign bus2.out_ready = tb_oready && (sel == 2);

`ifdef STR_PAIR_ASM_STATS_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;
`endif

    str_pair_assembler u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
`ifdef STR_PAIR_ASM_STATS_EN
        , .pair_cnt(cnt0)
`endif
    );

    str_pair_assembler #(.MAX_LEN(4)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
`ifdef STR_PAIR_ASM_STATS_EN
        , .pair_cnt(cnt1)
`endif
    );

    str_pair_assembler #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
`ifdef STR_PAIR_ASM_STATS_EN
        , .pair_cnt(cnt2)
`endif
    );

    logic  mon_valid;
    logic  mon_in_ready;
    logic  mon_err;
    string mon_fst;
    string mon_snd;

    always_comb begin
        mon_valid    = 1'b0;
        mon_in_ready = 1'b0;
        mon_err      = 1'b0;
        mon_fst      = "";
        mon_snd      = "";
        case (sel)
            0: begin
                mon_valid = bus0.out_valid; mon_in_ready = bus0.in_ready;
                mon_err = bus0.out_err; mon_fst = bus0.out_pair.fst; mon_snd = bus0.out_pair.snd;
            end
            1: begin
                mon_valid = bus1.out_valid; mon_in_ready = bus1.in_ready;
                mon_err = bus1.out_err; mon_fst = bus1.out_pair.fst; mon_snd = bus1.out_pair.snd;
            end
            default: begin
                mon_valid = bus2.out_valid; mon_in_ready = bus2.in_ready;
                mon_err = bus2.out_err; mon_fst = bus2.out_pair.fst; mon_snd = bus2.out_pair.snd;
            end
        endcase
    end

    task automatic chk_b(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input string obs, input string exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed \"%s\" required \"%s\"", tag, obs, exp);
        end
    endtask

    task automatic expect_pair(input string f, input string s, input logic e);
        q_fst.push_back(f);
        q_snd.push_back(s);
        q_err.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after acceptance
    task automatic send_char(input logic [7:0] c);
        int t;
        t = 0;
        tb_valid = 1'b1;
        tb_char  = c;
        while (!mon_in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!mon_in_ready) begin
            chk_b("send_timeout", 32'(mon_in_ready), 32'd1);
        end
        @(negedge clk);
        tb_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
        end
    endtask

    // Wait for a pair, optionally stall 5 cycles, compare against scoreboard
    task automatic collect(input bit stall);
        int    t;
        string e_f;
        string e_s;
        logic  e_e;
        t = 0;
        while (!mon_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk_b("collect_timeout", 32'(mon_valid), 32'd1);
        if (!mon_valid) return;
        if (q_fst.size() == 0) begin
            chk_b("scoreboard_empty", 32'(q_fst.size()), 32'd1);
            return;
        end
        e_f = q_fst.pop_front();
        e_s = q_snd.pop_front();
        e_e = q_err.pop_front();
        if (stall) begin
            repeat (5) begin
                @(negedge clk);
                chk_b("stall_valid", 32'(mon_valid), 32'd1);
                chk_b("stall_in_ready", 32'(mon_in_ready), 32'd0);
                chk_s("stall_fst", mon_fst, e_f);
                chk_s("stall_snd", mon_snd, e_s);
            end
            tb_oready = 1'b1;
        end
        chk_s("pair_fst", mon_fst, e_f);
        chk_s("pair_snd", mon_snd, e_s);
        chk_b("pair_err", 32'(mon_err), 32'(e_e));
        @(negedge clk);
    endtask

    task automatic do_reset();
        tb_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        do_reset();
        chk_b("rst_valid", 32'(mon_valid), 32'd0);
        chk_b("rst_err", 32'(mon_err), 32'd0);
        chk_b("rst_in_ready", 32'(mon_in_ready), 32'd1);
        chk_s("rst_fst", mon_fst, "");
        chk_s("rst_snd", mon_snd, "");
`ifdef STR_PAIR_ASM_STATS_EN
        chk_b("rst_cnt", 32'(cnt0), 32'd0);
`endif

        // Simple pair with out_ready held high: one-cycle valid pulse
        expect_pair("h", "i", 1'b0);
        send_str("h,i\n");
        chk_b("h_valid_rise", 32'(mon_valid), 32'd1);
        chk_b("h_in_ready_low", 32'(mon_in_ready), 32'd0);
        collect(1'b0);
        chk_b("h_valid_fall", 32'(mon_valid), 32'd0);
        chk_b("h_in_ready_back", 32'(mon_in_ready), 32'd1);

        // Back-to-back pairs with a 5-cycle stall on the first
        do_reset();
        @(negedge clk);
        expect_pair("hello", "world", 1'b0);
        expect_pair("test-word-1", "test-word-2", 1'b0);
        tb_oready = 1'b0;
        fork
            begin
                send_str("hello,world\n");
                send_str("test-word-1,test-word-2\n");
            end
            begin
                collect(1'b1);
                collect(1'b0);
            end
        join
`ifdef STR_PAIR_ASM_STATS_EN
        chk_b("b2b_cnt", 32'(cnt0), 32'd2);
`endif

        // Bare EOL gives two empty fields
        expect_pair("", "", 1'b0);
        send_str("\n");
        collect(1'b0);

        // NUL is discarded
        expect_pair("ab", "", 1'b0);
        send_char(8'h61);
        send_char(8'h00);
        send_char(8'h62);
        send_char(8'h2C);
        send_char(8'h0A);
        collect(1'b0);

        // Reset wins over a simultaneous handshake; pair not counted
        do_reset();
        @(negedge clk);
        tb_oready = 1'b0;
        send_str("z,z\n");
        chk_b("prio_valid_before", 32'(mon_valid), 32'd1);
        tb_oready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_b("prio_valid_after", 32'(mon_valid), 32'd0);
        chk_s("prio_fst", mon_fst, "");
`ifdef STR_PAIR_ASM_STATS_EN
        chk_b("prio_cnt", 32'(cnt0), 32'd0);
`endif

        // Reset mid-pair discards partial strings
        @(negedge clk);
        send_str("abc,de");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_s("mid_rst_fst", mon_fst, "");
        chk_s("mid_rst_snd", mon_snd, "");
        expect_pair("x", "y", 1'b0);
        send_str("x,y\n");
        collect(1'b0);
`ifdef STR_PAIR_ASM_STATS_EN
        chk_b("mid_rst_cnt", 32'(cnt0), 32'd1);
`endif

        // Truncation with MAX_LEN = 4; separator literal in snd
        sel = 1;
        @(negedge clk);
        expect_pair("abcd", "x,y", 1'b1);
        send_str("abcdef,x,y\n");
        collect(1'b0);
        expect_pair("a", "b", 1'b0);
        send_str("a,b\n");
        collect(1'b0);

        // Counter wrap with CNT_W = 2
        sel = 2;
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            expect_pair("p", "q", 1'b0);
            send_str("p,q\n");
            collect(1'b0);
        end
`ifdef STR_PAIR_ASM_STATS_EN
        chk_b("wrap_cnt", 32'(cnt2), 32'd1);
`endif
        chk_b("scoreboard_drained", 32'(q_fst.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_str_pair_assembler
`default_nettype wire
